// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Module   : regfile_write_arbiter_if
// Function : Writer-side handshakes and register-file write port of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              busy;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we3, wa3, wd3, busy
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we3, wa3, wd3, busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Function : Two small write FIFOs (ALU, load) sharing one register-file write
//            port; round-robin by default, fixed B priority with ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam int c_ENT_W = ADDR_W + DATA_W;

  logic [c_ENT_W-1:0] r_mem_a [DEPTH];
  logic [c_ENT_W-1:0] r_mem_b [DEPTH];
  logic [c_PTR_W-1:0] r_wp_a, r_rp_a, r_wp_b, r_rp_b;

  logic               r_we3;
  logic [ADDR_W-1:0]  r_wa3;
  logic [DATA_W-1:0]  r_wd3;

  logic               w_empty_a, w_empty_b, w_full_a, w_full_b;
  logic               w_push_a, w_push_b, w_grant_a, w_grant_b;
  logic [c_ENT_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty_a = (r_wp_a == r_rp_a);
  assign w_empty_b = (r_wp_b == r_rp_b);
  assign w_full_a  = (r_wp_a[c_PTR_W-1] != r_rp_a[c_PTR_W-1]) &&
                     (r_wp_a[c_IDX_W-1:0] == r_rp_a[c_IDX_W-1:0]);
  assign w_full_b  = (r_wp_b[c_PTR_W-1] != r_rp_b[c_PTR_W-1]) &&
                     (r_wp_b[c_IDX_W-1:0] == r_rp_b[c_IDX_W-1:0]);

  assign bus.a_ready = !w_full_a;
  assign bus.b_ready = !w_full_b;
  assign w_push_a    = bus.a_valid && !w_full_a;
  assign w_push_b    = bus.b_valid && !w_full_b;

`ifdef ARB_FIXED_PRIO_EN
  assign w_grant_b = !w_empty_b;
  assign w_grant_a = !w_empty_a && w_empty_b;
`else
  // r_last_b records which writer took the most recent grant (1 = B).
  logic r_last_b;

  assign w_grant_a = !w_empty_a && (w_empty_b || r_last_b);
  assign w_grant_b = !w_empty_b && (w_empty_a || !r_last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (w_grant_a) begin
      r_last_b <= 1'b0;
    end else if (w_grant_b) begin
      r_last_b <= 1'b1;
    end
  end
`endif

  assign w_head      = w_grant_a ? r_mem_a[r_rp_a[c_IDX_W-1:0]]
                                 : r_mem_b[r_rp_b[c_IDX_W-1:0]];
  assign w_head_addr = w_head[c_ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push_a) begin
      r_mem_a[r_wp_a[c_IDX_W-1:0]] <= {bus.a_addr, bus.a_data};
    end
    if (w_push_b) begin
      r_mem_b[r_wp_b[c_IDX_W-1:0]] <= {bus.b_addr, bus.b_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp_a <= '0;
      r_rp_a <= '0;
      r_wp_b <= '0;
      r_rp_b <= '0;
    end else begin
      if (w_push_a)  r_wp_a <= r_wp_a + c_PTR_W'(1);
      if (w_push_b)  r_wp_b <= r_wp_b + c_PTR_W'(1);
      if (w_grant_a) r_rp_a <= r_rp_a + c_PTR_W'(1);
      if (w_grant_b) r_rp_b <= r_rp_b + c_PTR_W'(1);
    end
  end

  // R0 grants still pop and update wa3/wd3, but never raise we3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else if (w_grant_a || w_grant_b) begin
      r_we3 <= (w_head_addr != '0);
      r_wa3 <= w_head_addr;
      r_wd3 <= w_head_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign bus.we3  = r_we3;
  assign bus.wa3  = r_wa3;
  assign bus.wd3  = r_wd3;
  assign bus.busy = !w_empty_a || !w_empty_b || r_we3;

endmodule

`default_nettype wire
